// File: rtl/hub_pkg.sv
// Shared definitions for the hub: default message width, counter sizing
// and helpers for addressing per-channel slices of packed vectors.
package hub_pkg;

  localparam int DEFAULT_HUB_FIFO_WIDTH = 32;

  // Pointer/occupancy width: one extra bit so that a full FIFO holds DEPTH
  // entries and full can be told apart from empty.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two and at least two.
  function automatic bit is_pow2_ge2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Low bit index of channel idx inside a packed vector of width-bit slices;
  // use as vec[slice_lo(idx, width) +: width].
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/hub_fifo_channel.sv
// One first-word-fall-through FIFO: register storage read combinationally at
// the read pointer, wrap-bit pointers for full/empty, occupancy count and a
// sticky flag recording any push attempted while full.
module hub_fifo_channel
  import hub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_HUB_FIFO_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    push_valid,
  output logic                    push_ready,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [cnt_w(DEPTH)-1:0] occupancy,
  output logic                    overflow_sticky
);

  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int ADDR_W = CNT_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, push, pop;

  // Flags come only from the pointer registers, so no input reaches them
  // combinationally. Full means the pointers are a whole lap apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // A push needs space before the edge, so a pop on a full FIFO cannot make
  // room for a push in the same cycle; a pop on an empty FIFO is ignored.
  assign push = push_valid && !full;
  assign pop  = pop_ready && !empty;

  // Next pointer and sticky-overflow values.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
    if (push_valid && full) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and flag registers; reset discards contents immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; its content only matters once valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
    end
  end

  assign pop_data        = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign pop_valid       = !empty;
  assign push_ready      = !full;
  assign occupancy       = wr_ptr_q - rd_ptr_q;
  assign overflow_sticky = overflow_q;

endmodule

// File: rtl/hub_fifo_bank.sv
// Bank of independent FWFT FIFOs, one per hub source channel, feeding the
// hub's priority mux through packed data/valid/ready vectors.
module hub_fifo_bank
  import hub_pkg::*;
#(
  parameter int HUB_FIFO_WIDTH  = DEFAULT_HUB_FIFO_WIDTH,
  parameter int TRUE_FIFO_COUNT = 3,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [TRUE_FIFO_COUNT*HUB_FIFO_WIDTH-1:0]      in_data_vector,
  input  logic [TRUE_FIFO_COUNT-1:0]                     in_valid_vector,
  output logic [TRUE_FIFO_COUNT-1:0]                     in_ready_vector,
  output logic [TRUE_FIFO_COUNT*HUB_FIFO_WIDTH-1:0]      combined_fifo_out_data_vector,
  output logic [TRUE_FIFO_COUNT-1:0]                     combined_fifo_out_valid_vector,
  input  logic [TRUE_FIFO_COUNT-1:0]                     combined_fifo_out_ready_vector,
  output logic [TRUE_FIFO_COUNT*cnt_w(FIFO_DEPTH)-1:0]   occupancy_vector,
  output logic [TRUE_FIFO_COUNT-1:0]                     overflow_sticky
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  // Reject depths the wrap-bit pointer scheme cannot represent.
  if (!is_pow2_ge2(FIFO_DEPTH)) begin : g_bad_depth
    $fatal(1, "hub_fifo_bank: FIFO_DEPTH must be a power of two and >= 2");
  end
  if (TRUE_FIFO_COUNT < 1) begin : g_bad_count
    $fatal(1, "hub_fifo_bank: TRUE_FIFO_COUNT must be >= 1");
  end

  // One FIFO per channel, each wired to its own slice of the packed vectors.
  for (genvar i = 0; i < TRUE_FIFO_COUNT; i++) begin : g_chan
    hub_fifo_channel #(
      .WIDTH (HUB_FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_chan (
      .clk             (clk),
      .reset_n         (reset_n),
      .push_data       (in_data_vector[slice_lo(i, HUB_FIFO_WIDTH) +: HUB_FIFO_WIDTH]),
      .push_valid      (in_valid_vector[i]),
      .push_ready      (in_ready_vector[i]),
      .pop_data        (combined_fifo_out_data_vector[slice_lo(i, HUB_FIFO_WIDTH) +: HUB_FIFO_WIDTH]),
      .pop_valid       (combined_fifo_out_valid_vector[i]),
      .pop_ready       (combined_fifo_out_ready_vector[i]),
      .occupancy       (occupancy_vector[slice_lo(i, CNT_W) +: CNT_W]),
      .overflow_sticky (overflow_sticky[i])
    );
  end

endmodule

// File: tb/tb_hub_fifo_bank.sv
// Scenario bench for hub_fifo_bank: a per-channel reference model keeps
// expected words in scoreboard queues when pushes are accepted, and each
// scenario compares popped words and flags against that model.
module tb_hub_fifo_bank;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int D  = 16;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*CW-1:0] occ;
  logic [N-1:0]   ovf;

  int pass_cnt  = 0;
  int check_cnt = 0;

  int             model_cnt [N];
  bit             model_ovf [N];
  logic [W-1:0]   sb0[$], sb1[$], sb2[$];
  bit             did_pop [N];
  logic [W-1:0]   exp_pop [N];
  logic [W-1:0]   obs_pop [N];

  always #5 clk = ~clk;

  hub_fifo_bank #(
    .HUB_FIFO_WIDTH  (W),
    .TRUE_FIFO_COUNT (N),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .in_data_vector                 (in_data),
    .in_valid_vector                (in_valid),
    .in_ready_vector                (in_ready),
    .combined_fifo_out_data_vector  (out_data),
    .combined_fifo_out_valid_vector (out_valid),
    .combined_fifo_out_ready_vector (out_ready),
    .occupancy_vector               (occ),
    .overflow_sticky                (ovf)
  );

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] ch_data(int c);
    return out_data[c*W +: W];
  endfunction

  function automatic logic [CW-1:0] ch_occ(int c);
    return occ[c*CW +: CW];
  endfunction

  task automatic sb_push(input int c, input logic [W-1:0] v);
    case (c)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int c, output logic [W-1:0] v);
    v = 'x;
    case (c)
      0: if (sb0.size() > 0) v = sb0.pop_front();
      1: if (sb1.size() > 0) v = sb1.pop_front();
      default: if (sb2.size() > 0) v = sb2.pop_front();
    endcase
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      model_cnt[c] = 0;
      model_ovf[c] = 1'b0;
      did_pop[c]   = 1'b0;
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  // Advance one clock: update the model from the inputs set up before the
  // edge, capture the head word the DUT shows for every model pop, then
  // return at the following falling edge.
  task automatic tick();
    int pre;
    bit push_ok, pop_ok;
    for (int c = 0; c < N; c++) begin
      pre        = model_cnt[c];
      push_ok    = in_valid[c] && (pre < D);
      pop_ok     = out_ready[c] && (pre > 0);
      did_pop[c] = pop_ok;
      if (in_valid[c] && pre == D) model_ovf[c] = 1'b1;
      if (pop_ok) begin
        sb_pop(c, exp_pop[c]);
        obs_pop[c] = ch_data(c);
      end
      if (push_ok) sb_push(c, in_data[c*W +: W]);
      model_cnt[c] = pre + int'(push_ok) - int'(pop_ok);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (out_valid !== 3'b000) $display("[TB] FAIL reset_out_valid: got %b expected %b", out_valid, 3'b000);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 3'b111) $display("[TB] FAIL reset_in_ready: got %b expected %b", in_ready, 3'b111);
    else pass_cnt++;
    check_cnt++;
    if (occ !== '0) $display("[TB] FAIL reset_occupancy: got %h expected 0", occ);
    else pass_cnt++;
    check_cnt++;
    if (ovf !== 3'b000) $display("[TB] FAIL reset_overflow: got %b expected %b", ovf, 3'b000);
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    in_data[1*W +: W] = 32'h0000_00A5;
    in_valid = 3'b010;
    tick();
    in_valid = '0;
    check_cnt++;
    if (out_valid[1] !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", out_valid[1]);
    else pass_cnt++;
    check_cnt++;
    if (ch_data(1) !== 32'h0000_00A5) $display("[TB] FAIL single_data: got %h expected %h", ch_data(1), 32'h0000_00A5);
    else pass_cnt++;
    check_cnt++;
    if (ch_occ(1) !== CW'(model_cnt[1])) $display("[TB] FAIL single_occ: got %0d expected %0d", ch_occ(1), model_cnt[1]);
    else pass_cnt++;
    out_ready = 3'b010;
    tick();
    out_ready = '0;
    check_cnt++;
    if (!did_pop[1] || obs_pop[1] !== exp_pop[1]) $display("[TB] FAIL single_pop_data: got %h expected %h", obs_pop[1], exp_pop[1]);
    else pass_cnt++;
    check_cnt++;
    if (out_valid[1] !== 1'b0) $display("[TB] FAIL single_empty_after_pop: got %b expected 0", out_valid[1]);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < D; i++) begin
      in_data[0 +: W] = $urandom;
      in_valid = 3'b001;
      tick();
    end
    in_valid = '0;
    check_cnt++;
    if (in_ready[0] !== 1'b0) $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready[0]);
    else pass_cnt++;
    check_cnt++;
    if (ch_occ(0) !== CW'(model_cnt[0])) $display("[TB] FAIL full_occ: got %0d expected %0d", ch_occ(0), model_cnt[0]);
    else pass_cnt++;
    check_cnt++;
    if (ovf !== 3'b000) $display("[TB] FAIL full_no_overflow_yet: got %b expected %b", ovf, 3'b000);
    else pass_cnt++;
    in_data[0 +: W] = 32'hDEAD_BEEF;
    in_valid = 3'b001;
    tick();
    in_valid = '0;
    check_cnt++;
    if (ovf !== {model_ovf[2], model_ovf[1], model_ovf[0]})
      $display("[TB] FAIL overflow_sticky: got %b expected %b", ovf, {model_ovf[2], model_ovf[1], model_ovf[0]});
    else pass_cnt++;
    check_cnt++;
    if (ch_occ(0) !== CW'(model_cnt[0])) $display("[TB] FAIL overflow_occ: got %0d expected %0d", ch_occ(0), model_cnt[0]);
    else pass_cnt++;
    check_cnt++;
    if (in_ready[2:1] !== 2'b11 || out_valid[2:1] !== 2'b00)
      $display("[TB] FAIL overflow_isolation: got ready=%b valid=%b expected ready=11 valid=00", in_ready[2:1], out_valid[2:1]);
    else pass_cnt++;
  endtask

  task automatic test_wrap_stream();
    int bad = 0;
    for (int k = 0; k < 5; k++) begin
      in_data[2*W +: W] = 32'h2000_0000 + k;
      in_valid = 3'b100;
      tick();
    end
    for (int k = 5; k < 45; k++) begin
      in_data[2*W +: W] = 32'h2000_0000 + k;
      in_valid  = 3'b100;
      out_ready = 3'b100;
      tick();
      check_cnt++;
      if (!did_pop[2] || obs_pop[2] !== exp_pop[2]) begin
        $display("[TB] FAIL stream_data[%0d]: got %h expected %h", k, obs_pop[2], exp_pop[2]);
      end else pass_cnt++;
      if (ch_occ(2) !== CW'(model_cnt[2])) bad++;
    end
    in_valid = '0;
    check_cnt++;
    if (bad != 0) $display("[TB] FAIL stream_occ: got %0d cycles off expected 0 (occupancy should hold %0d)", bad, model_cnt[2]);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_cnt++;
      if (!did_pop[2] || obs_pop[2] !== exp_pop[2]) $display("[TB] FAIL stream_drain[%0d]: got %h expected %h", k, obs_pop[2], exp_pop[2]);
      else pass_cnt++;
    end
    out_ready = '0;
    check_cnt++;
    if (out_valid[2] !== 1'b0) $display("[TB] FAIL stream_empty: got %b expected 0", out_valid[2]);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    in_data[0 +: W] = 32'hBAD0_0000;
    in_valid  = 3'b001;
    out_ready = 3'b001;
    tick();
    in_valid = '0;
    check_cnt++;
    if (!did_pop[0] || obs_pop[0] !== exp_pop[0]) $display("[TB] FAIL full_pushpop_data: got %h expected %h", obs_pop[0], exp_pop[0]);
    else pass_cnt++;
    check_cnt++;
    if (ch_occ(0) !== CW'(model_cnt[0])) $display("[TB] FAIL full_pushpop_occ: got %0d expected %0d", ch_occ(0), model_cnt[0]);
    else pass_cnt++;
    for (int k = 0; k < D - 1; k++) begin
      tick();
      check_cnt++;
      if (!did_pop[0] || obs_pop[0] !== exp_pop[0]) $display("[TB] FAIL full_drain[%0d]: got %h expected %h", k, obs_pop[0], exp_pop[0]);
      else pass_cnt++;
    end
    out_ready = '0;
    check_cnt++;
    if (out_valid[0] !== 1'b0 || ch_occ(0) !== 5'd0)
      $display("[TB] FAIL full_refused_word: got valid=%b occ=%0d expected valid=0 occ=0", out_valid[0], ch_occ(0));
    else pass_cnt++;
    in_data[2*W +: W] = 32'h0000_5A5A;
    in_valid  = 3'b100;
    out_ready = 3'b100;
    tick();
    in_valid  = '0;
    out_ready = '0;
    check_cnt++;
    if (ch_occ(2) !== CW'(model_cnt[2])) $display("[TB] FAIL empty_pushpop_occ: got %0d expected %0d", ch_occ(2), model_cnt[2]);
    else pass_cnt++;
    check_cnt++;
    if (ch_data(2) !== 32'h0000_5A5A) $display("[TB] FAIL empty_pushpop_data: got %h expected %h", ch_data(2), 32'h0000_5A5A);
    else pass_cnt++;
    out_ready = 3'b100;
    tick();
    out_ready = '0;
    check_cnt++;
    if (!did_pop[2] || obs_pop[2] !== exp_pop[2]) $display("[TB] FAIL empty_pushpop_drain: got %h expected %h", obs_pop[2], exp_pop[2]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < N; c++) in_data[c*W +: W] = (c << 8) | k;
      in_valid = 3'b111;
      tick();
    end
    in_valid = '0;
    for (int c = 0; c < N; c++) begin
      check_cnt++;
      if (ch_occ(c) !== CW'(model_cnt[c])) $display("[TB] FAIL mid_fill_occ[%0d]: got %0d expected %0d", c, ch_occ(c), model_cnt[c]);
      else pass_cnt++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if (out_valid !== 3'b000) $display("[TB] FAIL mid_reset_async_valid: got %b expected %b", out_valid, 3'b000);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (occ !== '0 || in_ready !== 3'b111)
      $display("[TB] FAIL mid_reset_release: got occ=%h ready=%b expected occ=0 ready=111", occ, in_ready);
    else pass_cnt++;
    check_cnt++;
    if (ovf !== {model_ovf[2], model_ovf[1], model_ovf[0]})
      $display("[TB] FAIL mid_reset_overflow: got %b expected %b", ovf, {model_ovf[2], model_ovf[1], model_ovf[0]});
    else pass_cnt++;
  endtask

  // Stand-in for the downstream priority mux: grant the lowest-index valid
  // channel each cycle; the model predicts which channel should win.
  task automatic test_mux_drain();
    int g_dut, g_exp;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < N; c++) in_data[c*W +: W] = 32'hC000_0000 | (c << 16) | k;
      in_valid = 3'b111;
      tick();
    end
    in_valid = '0;
    for (int n = 0; n < 4 * N; n++) begin
      g_dut = -1;
      g_exp = -1;
      for (int c = N - 1; c >= 0; c--) begin
        if (out_valid[c]) g_dut = c;
        if (model_cnt[c] > 0) g_exp = c;
      end
      check_cnt++;
      if (g_dut != g_exp) $display("[TB] FAIL mux_grant[%0d]: got %0d expected %0d", n, g_dut, g_exp);
      else pass_cnt++;
      out_ready = '0;
      if (g_dut >= 0) out_ready[g_dut] = 1'b1;
      tick();
      if (g_dut >= 0) begin
        check_cnt++;
        if (!did_pop[g_dut] || obs_pop[g_dut] !== exp_pop[g_dut])
          $display("[TB] FAIL mux_data[%0d]: got %h expected %h", n, obs_pop[g_dut], exp_pop[g_dut]);
        else pass_cnt++;
      end
    end
    out_ready = '0;
    check_cnt++;
    if (out_valid !== 3'b000) $display("[TB] FAIL mux_all_drained: got %b expected %b", out_valid, 3'b000);
    else pass_cnt++;
  endtask

  initial begin
    $display("[TB] hub_fifo_bank scenarios starting");
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_wrap_stream();
    test_simultaneous();
    test_reset_mid();
    test_mux_drain();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
